// File: rtl/musb_trace_buffer.sv
// ---------------------------------------------------------------------------
// musb_trace_buffer
//   On-chip event trace buffer. Captures time-stamped events from NUM_CH core
//   channels into a circular RAM. There are three capture modes: free-run
//   circular (0, and 3), stop-on-full (1), and triggered pre/post (2). The
//   captured entries are read back oldest-first through a pop port while the
//   buffer is idle or done.
//
// Ports
//   clk       clock
//   rst       asynchronous, active-low reset
//   arm       pulse: clear buffer, timestamp and flags, then start capture
//   abort     pulse: stop capture, return to IDLE, empty the buffer
//   mode      capture mode (0 free-run, 1 stop-on-full, 2 triggered, 3 = 0)
//   post_cnt  number of entries kept after the trigger (mode 2)
//   trig      trigger strobe (mode 2, honoured only in CAPTURE)
//   halt      core halted: pause capture and the timestamp
//   ev_valid  per-channel event strobes
//   ev_data   per-channel payloads; channel i is at [i*DATA_W +: DATA_W]
//   rd_en     pop the oldest entry
//   rd_valid  rd_data is valid; high for one cycle
//   rd_data   popped entry, packed as {ts, ch_id, data}
//   count     number of entries held
//   busy      state is CAPTURE or POST
//   done      state is DONE
//   overflow  sticky: an older entry was overwritten
//   drop_cnt  saturating count of cycles in which a valid event lost
//             arbitration
// ---------------------------------------------------------------------------
module musb_trace_buffer #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 6,
    parameter int TS_W       = 16,
    parameter int DROP_W     = 8,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int ENTRY_W    = TS_W + CH_W + DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [1:0]               mode,
    input  logic [DEPTH_LOG2:0]      post_cnt,
    input  logic                     trig,
    input  logic                     halt,
    input  logic [NUM_CH-1:0]        ev_valid,
    input  logic [NUM_CH*DATA_W-1:0] ev_data,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [ENTRY_W-1:0]       rd_data,
    output logic [DEPTH_LOG2:0]      count,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_C   = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [TS_W-1:0]       TS_ONE    = TS_W'(1);
    localparam logic [DROP_W-1:0]     DROP_ONE  = DROP_W'(1);
    localparam logic [DROP_W-1:0]     DROP_MAX  = {DROP_W{1'b1}};
    localparam logic [NUM_CH-1:0]     VALID_ONE = NUM_CH'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        POST    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state_reg;
    logic [DEPTH_LOG2-1:0]   wptr_reg;
    logic [DEPTH_LOG2-1:0]   rptr_reg;
    logic [TS_W-1:0]         ts_reg;
    logic [DEPTH_LOG2:0]     remaining_reg;

    logic [ENTRY_W-1:0]      mem [DEPTH];

    // Per-channel payload slices
    logic [DATA_W-1:0]       ch_data [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_slice
            assign ch_data[gi] = ev_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // The lowest-index valid channel wins. The loop runs downwards so that
    // the last assignment made comes from the lowest valid index.
    logic [CH_W-1:0]   sel_ch;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        sel_ch   = '0;
        sel_data = ch_data[0];
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ev_valid[i]) begin
                sel_ch   = CH_W'(i);
                sel_data = ch_data[i];
            end
        end
    end

    logic               any_valid;
    logic               multi_valid;
    logic               full;
    logic               stop_on_full;
    logic               trig_mode;
    logic               capturing;
    logic               wr_en;
    logic [ENTRY_W-1:0] wr_entry;

    assign any_valid    = |ev_valid;
    // Clearing the lowest set bit leaves a non-zero value when more than one
    // bit was set.
    assign multi_valid  = |(ev_valid & (ev_valid - VALID_ONE));
    assign full         = (count == DEPTH_C);
    assign stop_on_full = (mode == 2'd1);
    assign trig_mode    = (mode == 2'd2);

    // A write is allowed in CAPTURE, and in POST while post-trigger entries
    // are still owed. A write is blocked when stop-on-full mode is already
    // full, and in any cycle where arm or abort restarts the buffer.
    assign capturing = (state_reg == CAPTURE) ||
                       ((state_reg == POST) && (remaining_reg != '0));
    assign wr_en     = capturing && !halt && any_valid && !abort && !arm &&
                       !(stop_on_full && full);
    assign wr_entry  = {ts_reg, sel_ch, sel_data};

    // Trace RAM: the write port has no reset. Stale contents are never
    // visible, because count bounds every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_reg] <= wr_entry;
        end
    end

    assign busy = (state_reg == CAPTURE) || (state_reg == POST);
    assign done = (state_reg == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            ts_reg        <= '0;
            remaining_reg <= '0;
            count         <= '0;
            drop_cnt      <= '0;
            overflow      <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (abort) begin
                state_reg     <= IDLE;
                wptr_reg      <= '0;
                rptr_reg      <= '0;
                count         <= '0;
                remaining_reg <= '0;
            end else if (arm) begin
                state_reg     <= CAPTURE;
                wptr_reg      <= '0;
                rptr_reg      <= '0;
                count         <= '0;
                remaining_reg <= '0;
                ts_reg        <= '0;
                overflow      <= 1'b0;
                drop_cnt      <= '0;
            end else begin
                case (state_reg)
                    IDLE, DONE: begin
                        if (rd_en && (count != '0)) begin
                            rd_data  <= mem[rptr_reg];
                            rd_valid <= 1'b1;
                            rptr_reg <= rptr_reg + PTR_ONE;
                            count    <= count - CNT_ONE;
                        end
                    end
                    CAPTURE, POST: begin
                        if (!halt) begin
                            ts_reg <= ts_reg + TS_ONE;
                            if (wr_en) begin
                                wptr_reg <= wptr_reg + PTR_ONE;
                                // When full, the oldest entry is overwritten:
                                // the read side moves forward with the write
                                // side.
                                if (full) begin
                                    rptr_reg <= rptr_reg + PTR_ONE;
                                    overflow <= 1'b1;
                                end else begin
                                    count <= count + CNT_ONE;
                                end
                                if (multi_valid && (drop_cnt != DROP_MAX)) begin
                                    drop_cnt <= drop_cnt + DROP_ONE;
                                end
                                if (state_reg == POST) begin
                                    remaining_reg <= remaining_reg - CNT_ONE;
                                end
                                if (stop_on_full && (count == DEPTH_C - CNT_ONE)) begin
                                    state_reg <= DONE;
                                end
                            end
                            if ((state_reg == POST) && (remaining_reg == '0)) begin
                                state_reg <= DONE;
                            end
                        end
                        // The trigger is honoured even while halted. The
                        // event in the trigger cycle is written but does not
                        // count toward the post-trigger entries.
                        if ((state_reg == CAPTURE) && trig && trig_mode) begin
                            state_reg     <= POST;
                            remaining_reg <= (post_cnt > DEPTH_C) ? DEPTH_C : post_cnt;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_musb_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_musb_trace_buffer
//   Directed scenarios followed by a randomized run. All of them are checked
//   every cycle against a queue-based reference model of the trace buffer.
// ---------------------------------------------------------------------------
module tb_musb_trace_buffer;

    localparam int NUM_CH     = 4;
    localparam int DATA_W     = 32;
    localparam int DEPTH_LOG2 = 6;
    localparam int TS_W       = 16;
    localparam int DROP_W     = 8;
    localparam int CH_W       = 2;
    localparam int ENTRY_W    = TS_W + CH_W + DATA_W;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    localparam int S_IDLE = 0;
    localparam int S_CAP  = 1;
    localparam int S_POST = 2;
    localparam int S_DONE = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     arm;
    logic                     abort;
    logic [1:0]               mode;
    logic [DEPTH_LOG2:0]      post_cnt;
    logic                     trig;
    logic                     halt;
    logic [NUM_CH-1:0]        ev_valid;
    logic [NUM_CH*DATA_W-1:0] ev_data;
    logic                     rd_en;
    logic                     rd_valid;
    logic [ENTRY_W-1:0]       rd_data;
    logic [DEPTH_LOG2:0]      count;
    logic                     busy;
    logic                     done;
    logic                     overflow;
    logic [DROP_W-1:0]        drop_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int                 m_state;
    logic [ENTRY_W-1:0] q[$];
    logic [TS_W-1:0]    m_ts;
    logic [DROP_W-1:0]  m_drop;
    logic               m_ovf;
    int                 m_rem;
    logic               m_rdv;
    logic [ENTRY_W-1:0] m_rdd;

    musb_trace_buffer #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2),
        .TS_W(TS_W), .DROP_W(DROP_W)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .mode(mode),
        .post_cnt(post_cnt), .trig(trig), .halt(halt), .ev_valid(ev_valid),
        .ev_data(ev_data), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .count(count), .busy(busy), .done(done), .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        q.delete();
        m_ts   = '0;
        m_drop = '0;
        m_ovf  = 1'b0;
        m_rem  = 0;
        m_rdv  = 1'b0;
        m_rdd  = '0;
    endtask

    // Spec-level behaviour: the buffer is a bounded queue of entries.
    task automatic model_update();
        int st;
        int ch;
        logic [DATA_W-1:0] d;
        st    = m_state;
        m_rdv = 1'b0;
        if (abort) begin
            m_state = S_IDLE;
            q.delete();
            m_rem = 0;
        end else if (arm) begin
            m_state = S_CAP;
            q.delete();
            m_ts   = '0;
            m_ovf  = 1'b0;
            m_drop = '0;
            m_rem  = 0;
        end else if (st == S_IDLE || st == S_DONE) begin
            if (rd_en && q.size() > 0) begin
                m_rdd = q.pop_front();
                m_rdv = 1'b1;
            end
        end else begin
            if (!halt) begin
                if (st == S_POST && m_rem == 0) begin
                    m_state = S_DONE;
                end else if (ev_valid != 0 && !(mode == 2'd1 && q.size() == DEPTH)) begin
                    ch = 0;
                    while (!ev_valid[ch]) ch++;
                    d = ev_data[ch*DATA_W +: DATA_W];
                    if (q.size() == DEPTH) begin
                        void'(q.pop_front());
                        m_ovf = 1'b1;
                    end
                    q.push_back({m_ts, CH_W'(ch), d});
                    if ($countones(ev_valid) > 1 && m_drop != 8'hFF) m_drop++;
                    if (st == S_POST) m_rem--;
                    if (mode == 2'd1 && q.size() == DEPTH) m_state = S_DONE;
                end
                m_ts++;
            end
            if (st == S_CAP && trig && mode == 2'd2) begin
                m_state = S_POST;
                m_rem   = (int'(post_cnt) > DEPTH) ? DEPTH : int'(post_cnt);
            end
        end
    endtask

    task automatic check_all();
        chk("count",    64'(count),    64'(q.size()));
        chk("busy",     64'(busy),     64'(m_state == S_CAP || m_state == S_POST));
        chk("done",     64'(done),     64'(m_state == S_DONE));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
        chk("rd_data",  64'(rd_data),  64'(m_rdd));
    endtask

    // One clock: inputs are already set; update the model, check, clear pulses.
    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else model_update();
        #1;
        check_all();
        arm      = 1'b0;
        abort    = 1'b0;
        trig     = 1'b0;
        rd_en    = 1'b0;
        halt     = 1'b0;
        ev_valid = '0;
    endtask

    task automatic do_arm(input logic [1:0] m);
        mode = m;
        arm  = 1'b1;
        step();
    endtask

    // Ends a capture by switching to triggered mode with zero post entries.
    task automatic stop_capture();
        mode     = 2'd2;
        post_cnt = '0;
        trig     = 1'b1;
        step();
        step();
        chk("stopped_done", 64'(done), 64'd1);
    endtask

    task automatic event_all(input int k);
        ev_valid = 4'b0001;
        ev_data  = {4{32'(k)}};
        step();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
    endtask

    initial begin
        logic [ENTRY_W-1:0] e;
        int n;
        rst = 1'b0; arm = 0; abort = 0; mode = 0; post_cnt = 0; trig = 0;
        halt = 0; ev_valid = 0; ev_data = '0; rd_en = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        step();

        // Scenario 1: five ch1 events, popped in order with ts 0..4
        do_arm(2'd0);
        for (int i = 0; i < 5; i++) begin
            ev_valid = 4'b0010;
            ev_data  = {$urandom(), $urandom(), 32'(32'h10 + i), $urandom()};
            step();
        end
        stop_capture();
        for (int i = 0; i < 5; i++) begin
            pop();
            e = {16'(i), 2'd1, 32'(32'h10 + i)};
            chk("s1_pop", 64'(rd_data), 64'(e));
        end

        // Scenario 2: stop-on-full with 70 events
        do_arm(2'd1);
        for (int k = 0; k < 70; k++) event_all(k);
        chk("s2_done", 64'(done), 64'd1);
        chk("s2_count", 64'(count), 64'd64);
        chk("s2_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 64; i++) pop();
        chk("s2_last", 64'(rd_data[DATA_W-1:0]), 64'd63);

        // Scenario 3: free-run with 70 events wraps
        do_arm(2'd0);
        for (int k = 0; k < 70; k++) event_all(k);
        chk("s3_count", 64'(count), 64'd64);
        chk("s3_ovf", 64'(overflow), 64'd1);
        stop_capture();
        pop();
        chk("s3_first", 64'(rd_data[DATA_W-1:0]), 64'd6);
        while (count != 0 && checks < 1000000) pop();

        // Scenario 4: triggered, post_cnt 3, trigger at event 10 of 20
        do_arm(2'd2);
        for (int k = 0; k < 20; k++) begin
            if (k == 10) begin
                trig = 1'b1;
                post_cnt = 7'd3;
            end
            event_all(k);
        end
        chk("s4_done", 64'(done), 64'd1);
        chk("s4_busy", 64'(busy), 64'd0);
        chk("s4_count", 64'(count), 64'd14);
        for (int i = 0; i < 14; i++) pop();
        chk("s4_last", 64'(rd_data[DATA_W-1:0]), 64'd13);

        // Scenario 5: arbitration and drop count; a halt leaves no ts gap
        do_arm(2'd0);
        ev_valid = 4'b1010;
        ev_data  = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
        step();
        chk("s5_drop", 64'(drop_cnt), 64'd1);
        event_all(100);
        for (int i = 0; i < 4; i++) begin
            halt = 1'b1;
            ev_valid = 4'b1111;
            step();
        end
        event_all(101);
        chk("s5_drop_after_halt", 64'(drop_cnt), 64'd1);
        stop_capture();
        pop();
        e = {16'd0, 2'd1, 32'hB1};
        chk("s5_arb_entry", 64'(rd_data), 64'(e));
        pop();
        pop();
        chk("s5_ts_no_gap", 64'(rd_data[ENTRY_W-1 -: TS_W]), 64'd2);

        // Scenario 6: abort in POST, then a read from the empty buffer
        do_arm(2'd2);
        for (int k = 0; k < 4; k++) event_all(k);
        trig = 1'b1;
        post_cnt = 7'd10;
        event_all(4);
        event_all(5);
        chk("s6_busy_post", 64'(busy), 64'd1);
        abort = 1'b1;
        step();
        chk("s6_count", 64'(count), 64'd0);
        chk("s6_busy", 64'(busy), 64'd0);
        pop();
        chk("s6_rdv", 64'(rd_valid), 64'd0);

        // Randomized run, checked against the model every cycle
        do_arm(2'd2);
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                arm  = 1'b1;
                mode = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 299) == 0) abort = 1'b1;
            trig     = ($urandom_range(0, 24) == 0);
            post_cnt = 7'($urandom_range(0, 127));
            halt     = ($urandom_range(0, 7) == 0);
            ev_valid = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom());
            ev_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            rd_en    = 1'($urandom_range(0, 1));
            step();
        end

        // Scenario 7: asynchronous reset in the middle of a capture
        do_arm(2'd0);
        for (int k = 0; k < 3; k++) event_all(k);
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        step();
        rst = 1'b1;
        step();
        do_arm(2'd0);
        event_all(77);
        stop_capture();
        n = int'(count);
        chk("s7_count", 64'(n), 64'd1);
        pop();
        e = {16'd0, 2'd0, 32'd77};
        chk("s7_entry", 64'(rd_data), 64'(e));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
